catc_stall_arbiter: RTL and testbench

CATC_STALL_ARBITER -- requirements
Module: catc_stall_arbiter

---
 rtl/catc_stall_arbiter.sv | 158 +++++++++++++++
 tb/tb_catc_stall_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/catc_stall_arbiter.sv
// catc_stall_arbiter: round-robin arbiter for stall requests on a controlled
// RetroCATC. It grants at most one requester at a time and bounds each grant
// to MaxStall cycles. After each grant it forces Cooldown idle cycles. It also
// tracks how many reference ticks the stalled core owes (Debt), so the core can
// catch up and so new grants are refused while the debt is too large.
module catc_stall_arbiter #(
  parameter int Requesters = 4,
  parameter int MaxStall   = 256,
  parameter int Cooldown   = 2,
  parameter int DebtLimit  = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [Requesters-1:0] req,
  input  logic                  ref_tick,
  input  logic                  core_tick,
  output logic [Requesters-1:0] grant,
  output logic                  stall,
  output logic                  fast_catchup,
  output logic [15:0]           debt,
  output logic [Requesters-1:0] timeout
);

  localparam int IDX_W  = $clog2(Requesters);
  localparam int HOLD_W = $clog2(MaxStall + 1);
  localparam int CD_W   = (Cooldown > 1) ? $clog2(Cooldown) : 1;

  localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(MaxStall - 1);
  localparam logic [CD_W-1:0]       CD_LAST   = CD_W'((Cooldown > 0) ? Cooldown - 1 : 0);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(Requesters - 1);
  localparam logic [Requesters-1:0] ONE       = Requesters'(1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    COOLDOWN
  } state_t;

  state_t                  state;
  logic [Requesters-1:0]   mask;
  logic [HOLD_W-1:0]       hold_cnt;
  logic [CD_W-1:0]         cd_cnt;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        holder;
  logic                    armed;

  logic [Requesters-1:0]   eligible;
  logic                    pick_valid;
  logic [IDX_W-1:0]        pick_idx;
  logic [IDX_W-1:0]        next_ptr;
  logic                    can_grant;
  logic [15:0]             debt_next;
  int                      idx;

  // Saturating up/down step of the tick debt; simultaneous ticks cancel.
  function automatic logic [15:0] debt_step(input logic [15:0] cur,
                                            input logic        up,
                                            input logic        dn);
    logic [15:0] res;
    res = cur;
    if (up && !dn && cur != 16'hFFFF)
      res = cur + 16'd1;
    else if (dn && !up && cur != 16'd0)
      res = cur - 16'd1;
    return res;
  endfunction

  assign eligible  = req & ~mask;
  assign debt_next = debt_step(debt, ref_tick, core_tick);
  assign next_ptr  = (pick_idx == IDX_LAST) ? '0 : pick_idx + 1'b1;
  // armed holds off the very first edge after reset so a grant needs two edges.
  assign can_grant = armed && pick_valid && ({16'd0, debt} < 32'(DebtLimit));

  // Round-robin pick: scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int k = Requesters - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= Requesters)
        idx = idx - Requesters;
      if (eligible[idx[IDX_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = idx[IDX_W-1:0];
      end
    end
  end

  // Grant FSM: all outputs registered, Stall mirrors the registered grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      stall    <= 1'b0;
      timeout  <= '0;
      mask     <= '0;
      hold_cnt <= '0;
      cd_cnt   <= '0;
      rr_ptr   <= '0;
      holder   <= '0;
      armed    <= 1'b0;
    end else begin
      armed   <= 1'b1;
      timeout <= '0;
      mask    <= mask & req;
      case (state)
        IDLE: begin
          if (can_grant) begin
            state    <= GRANT;
            grant    <= ONE << pick_idx;
            stall    <= 1'b1;
            holder   <= pick_idx;
            hold_cnt <= '0;
            rr_ptr   <= next_ptr;
          end
        end
        GRANT: begin
          if (!req[holder] || hold_cnt == HOLD_LAST) begin
            grant  <= '0;
            stall  <= 1'b0;
            cd_cnt <= '0;
            if (Cooldown == 0)
              state <= IDLE;
            else
              state <= COOLDOWN;
            // Still requesting at the limit: revoke and lock out until Req falls.
            if (req[holder]) begin
              timeout <= grant;
              mask    <= (mask & req) | grant;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        COOLDOWN: begin
          if (cd_cnt == CD_LAST)
            state <= IDLE;
          else
            cd_cnt <= cd_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tick debt and catch-up flag, updated every cycle regardless of state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      debt         <= 16'd0;
      fast_catchup <= 1'b0;
    end else begin
      debt         <= debt_next;
      fast_catchup <= (debt_next != 16'd0);
    end
  end

endmodule

// File: tb/tb_catc_stall_arbiter.sv
// Directed bench for catc_stall_arbiter with default parameters.
module tb_catc_stall_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic        ref_tick;
  logic        core_tick;
  logic [3:0]  grant;
  logic        stall;
  logic        fast_catchup;
  logic [15:0] debt;
  logic [3:0]  timeout;

  int checks = 0;
  int errors = 0;
  int cnt, tcnt, tidx, n;
  logic [3:0] tval;
  logic seen;
  int order [5] = '{0, 1, 2, 3, 0};

  catc_stall_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .ref_tick     (ref_tick),
    .core_tick    (core_tick),
    .grant        (grant),
    .stall        (stall),
    .fast_catchup (fast_catchup),
    .debt         (debt),
    .timeout      (timeout)
  );

  initial forever #5 clk = ~clk;

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; ref_tick = 1'b0; core_tick = 1'b0;
    @(posedge clk); #1;
    chk("rst_grant", grant, 0);
    chk("rst_stall", stall, 0);
    chk("rst_fc", fast_catchup, 0);
    chk("rst_debt", debt, 0);
    chk("rst_timeout", timeout, 0);

    // First grant needs two edges after reset release
    rst = 1'b0; req = 4'b0001;
    step(1); chk("first_edge_nogrant", grant, 0);
    step(1); chk("second_edge_grant", grant, 4'b0001);
    chk("second_edge_stall", stall, 1);
    req = '0; step(5);

    // Single requester for 10 cycles, then cooldown
    req = 4'b0001; cnt = 0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      if (c == 0) chk("single_first_grant", grant, 4'b0001);
      if (stall) cnt++;
    end
    req = '0; step(1);
    chk("single_release", grant, 0);
    chk("single_stall_cycles", cnt, 10);
    req = 4'b0001;
    step(1); chk("single_cd1", grant, 0);
    step(1); chk("single_cd2", grant, 0);
    step(1); chk("single_regrant", grant, 4'b0001);
    req = '0; step(5);

    // Reset mid-grant with Debt=100
    req = 4'b0100; ref_tick = 1'b1;
    step(100); ref_tick = 1'b0;
    chk("pre_rst_debt", debt, 100);
    chk("pre_rst_grant", grant, 4'b0100);
    chk("pre_rst_fc", fast_catchup, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_stall", stall, 0);
    chk("async_rst_grant", grant, 0);
    chk("async_rst_debt", debt, 0);
    chk("async_rst_fc", fast_catchup, 0);
    req = '0; step(1);
    chk("in_rst_grant", grant, 0);

    // Round-robin order with all requesting
    rst = 1'b0; req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (grant === 4'b0000 && n < 20) begin
        step(1);
        n++;
      end
      chk("rr_gap", n, (g == 0) ? 2 : 3);
      chk("rr_order", grant, 4'b0001 << order[g]);
      step(4);
      chk("rr_hold", grant, 4'b0001 << order[g]);
      req[order[g]] = 1'b0;
      step(1);
      chk("rr_release", grant, 0);
      req[order[g]] = 1'b1;
    end
    req = '0; step(5);

    // Timeout after MaxStall with Req held
    req = 4'b0100; cnt = 0; tcnt = 0; tidx = 0; tval = '0;
    for (int c = 1; c <= 300; c++) begin
      step(1);
      if (grant[2]) cnt++;
      if (timeout != 4'b0000) begin
        tcnt++;
        tidx = c;
        tval = timeout;
      end
    end
    chk("to_grant_cycles", cnt, 256);
    chk("to_pulse_count", tcnt, 1);
    chk("to_pulse_cycle", tidx, 257);
    chk("to_pulse_value", tval, 4'b0100);
    req = '0; step(1);
    req = 4'b0100; step(1);
    chk("to_regrant_after_drop", grant, 4'b0100);
    req = '0; step(5);

    // Debt floor and cancellation
    ref_tick = 1'b1; core_tick = 1'b1; step(1);
    chk("both_ticks_debt", debt, 0);
    chk("both_ticks_fc", fast_catchup, 0);
    ref_tick = 1'b0; step(1);
    chk("no_underflow", debt, 0);
    core_tick = 1'b0; ref_tick = 1'b1; step(3);
    chk("debt_up3", debt, 3);
    chk("debt_up3_fc", fast_catchup, 1);
    ref_tick = 1'b0; core_tick = 1'b1; step(3); core_tick = 1'b0;
    chk("debt_down0", debt, 0);
    chk("debt_down0_fc", fast_catchup, 0);

    // Debt limit blocks new grants only
    req = 4'b0001; ref_tick = 1'b1;
    step(4096); ref_tick = 1'b0;
    chk("limit_debt", debt, 4096);
    chk("limit_fc", fast_catchup, 1);
    req = 4'b0011; seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      if (grant != 4'b0000) seen = 1'b1;
    end
    chk("limit_blocked", seen, 0);
    core_tick = 1'b1; step(1); core_tick = 1'b0;
    chk("limit_debt_dec", debt, 4095);
    chk("limit_dec_fc", fast_catchup, 1);
    chk("limit_dec_nogrant", grant, 0);
    step(1);
    chk("limit_grant_req1", grant, 4'b0010);
    ref_tick = 1'b1; step(1); ref_tick = 1'b0;
    chk("limit_debt_again", debt, 4096);
    chk("limit_active_grant_kept", grant, 4'b0010);
    req = '0; step(1);
    chk("limit_release", grant, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
